// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider sequencer (div_ctrl).
// Holds the FSM state encoding, the divide-by-zero quotient and the divider result field layout.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Divider result word: quotient in the upper half, remainder in the lower half.
  localparam int DOUT_QUOT_LSB = 32;
  localparam int DOUT_REM_LSB  = 0;

  function automatic logic [31:0] dout_field(input logic [63:0] dout, input logic rem);
    return rem ? dout[DOUT_REM_LSB +: 32] : dout[DOUT_QUOT_LSB +: 32];
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencer for the shared 32-bit AXI-stream divider: issue, wait, hold result for WB, flush handling.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor is answered locally without touching the divider.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int LAT_MAX = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_rem,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        cancel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        err_timeout,
  output logic        div_signed,
  output logic        div_dividend_tvalid,
  input  logic        div_dividend_tready,
  output logic [31:0] div_dividend_tdata,
  output logic        div_divisor_tvalid,
  input  logic        div_divisor_tready,
  output logic [31:0] div_divisor_tdata,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata
);

  localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(LAT_MAX);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_signed;
  logic              r_rem;
  logic [31:0]       r_src1;
  logic [31:0]       r_src2;
  logic [31:0]       r_result;
  logic              r_dd_done;
  logic              r_dv_done;
  logic              r_cancel_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic              w_dd_tvalid;
  logic              w_dv_tvalid;
  logic              w_dd_fin;
  logic              w_dv_fin;
  logic              w_accept;
  logic              w_load_result;
  logic [31:0]       w_result_next;

  // Each channel keeps tvalid up until its own handshake, independent of the other channel.
  assign w_dd_tvalid = (r_state == ISSUE) && !r_dd_done;
  assign w_dv_tvalid = (r_state == ISSUE) && !r_dv_done;
  assign w_dd_fin    = r_dd_done || (w_dd_tvalid && div_dividend_tready);
  assign w_dv_fin    = r_dv_done || (w_dv_tvalid && div_divisor_tready);

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_load_result = 1'b0;
    w_result_next = dout_field(div_dout_tdata, r_rem);
    case (r_state)
      IDLE: begin
        if (req_valid && !cancel) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (req_src2 == 32'd0) begin
            w_load_result = 1'b1;
            w_result_next = req_rem ? req_src1 : DIV_ZERO_QUOT;
            w_state_next  = DONE;
          end
`endif
        end
      end
      ISSUE: begin
        if (w_dd_fin && w_dv_fin)
          w_state_next = (r_cancel_pend || cancel) ? DRAIN : WAIT;
      end
      WAIT: begin
        if (div_dout_tvalid) begin
          if (cancel) begin
            w_state_next = IDLE;
          end else begin
            w_load_result = 1'b1;
            w_state_next  = DONE;
          end
        end else if (cancel) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (div_dout_tvalid) w_state_next = IDLE;
      end
      DONE: begin
        if (resp_ready || cancel) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_signed      <= 1'b0;
      r_rem         <= 1'b0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_result      <= '0;
      r_dd_done     <= 1'b0;
      r_dv_done     <= 1'b0;
      r_cancel_pend <= 1'b0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_signed      <= req_signed;
        r_rem         <= req_rem;
        r_src1        <= req_src1;
        r_src2        <= req_src2;
        r_dd_done     <= 1'b0;
        r_dv_done     <= 1'b0;
        r_cancel_pend <= 1'b0;
        r_cnt         <= '0;
      end
      if (r_state == ISSUE) begin
        if (w_dd_tvalid && div_dividend_tready) r_dd_done <= 1'b1;
        if (w_dv_tvalid && div_divisor_tready)  r_dv_done <= 1'b1;
        if (cancel)                             r_cancel_pend <= 1'b1;
      end
      // Counter saturates at the limit; the timeout flag is sticky and never aborts the wait.
      if (r_state == WAIT) begin
        if (r_cnt != LAT_LIMIT) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == LAT_LIMIT) r_err <= 1'b1;
      end
      if (w_load_result) r_result <= w_result_next;
    end
  end

  assign req_ready           = (r_state == IDLE);
  assign busy                = (r_state != IDLE);
  assign resp_valid          = (r_state == DONE);
  assign resp_data           = r_result;
  assign err_timeout         = r_err;
  assign div_signed          = r_signed;
  assign div_dividend_tvalid = w_dd_tvalid;
  assign div_divisor_tvalid  = w_dv_tvalid;
  assign div_dividend_tdata  = r_src1;
  assign div_divisor_tdata   = r_src2;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider model plus arithmetic reference results.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic        req_rem = 1'b0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        cancel = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy;
  logic        err_timeout;
  logic        div_signed;
  logic        div_dividend_tvalid;
  logic        div_dividend_tready = 1'b0;
  logic [31:0] div_dividend_tdata;
  logic        div_divisor_tvalid;
  logic        div_divisor_tready = 1'b0;
  logic [31:0] div_divisor_tdata;
  logic        div_dout_tvalid = 1'b0;
  logic [63:0] div_dout_tdata = '0;

  div_ctrl dut (
    .clk                 (clk),
    .resetn              (resetn),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_signed          (req_signed),
    .req_rem             (req_rem),
    .req_src1            (req_src1),
    .req_src2            (req_src2),
    .cancel              (cancel),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_data           (resp_data),
    .busy                (busy),
    .err_timeout         (err_timeout),
    .div_signed          (div_signed),
    .div_dividend_tvalid (div_dividend_tvalid),
    .div_dividend_tready (div_dividend_tready),
    .div_dividend_tdata  (div_dividend_tdata),
    .div_divisor_tvalid  (div_divisor_tvalid),
    .div_divisor_tready  (div_divisor_tready),
    .div_divisor_tdata   (div_divisor_tdata),
    .div_dout_tvalid     (div_dout_tvalid),
    .div_dout_tdata      (div_dout_tdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Divider model configuration and observation counters
  int          cfg_dd_delay = 0;
  int          cfg_dv_delay = 0;
  int          cfg_lat      = 2;
  int          dd_cnt = 0, dv_cnt = 0, lat_cnt = 0;
  bit          got_dd = 0, got_dv = 0, pending = 0;
  logic [31:0] cap_a, cap_b, dd_first, dv_first;
  logic [63:0] pend_res;
  int          n_dout = 0, dd_tv_cycles = 0, dv_tv_cycles = 0;
  int          dd_unstable = 0, dv_unstable = 0;
  int          n_rv = 0, n_resp = 0, sig_bad = 0, hold_bad = 0;
  logic        cur_sgn = 1'b0;

  // {quotient, remainder} by plain arithmetic, RISC-V style corner cases.
  function automatic logic [63:0] ref_qr(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic rem);
    logic [63:0] qr;
    qr = ref_qr(a, b, sgn);
    return rem ? qr[31:0] : qr[63:32];
  endfunction

  // Divider model: inputs change on the falling edge, handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      div_dividend_tready = 1'b0; div_divisor_tready = 1'b0; div_dout_tvalid = 1'b0;
      got_dd = 0; got_dv = 0; pending = 0; dd_cnt = 0; dv_cnt = 0;
    end else begin
      div_dout_tvalid = 1'b0;
      if (pending) begin
        if (lat_cnt == 0) begin
          div_dout_tvalid = 1'b1; div_dout_tdata = pend_res; pending = 0; n_dout++;
        end else lat_cnt--;
      end
      div_dividend_tready = 1'b0;
      if (div_dividend_tvalid) begin
        dd_tv_cycles++;
        if (dd_cnt == 0) dd_first = div_dividend_tdata;
        else if (div_dividend_tdata !== dd_first) dd_unstable++;
        if (dd_cnt >= cfg_dd_delay) begin
          div_dividend_tready = 1'b1; cap_a = div_dividend_tdata; got_dd = 1;
        end
        dd_cnt++;
      end else dd_cnt = 0;
      div_divisor_tready = 1'b0;
      if (div_divisor_tvalid) begin
        dv_tv_cycles++;
        if (dv_cnt == 0) dv_first = div_divisor_tdata;
        else if (div_divisor_tdata !== dv_first) dv_unstable++;
        if (dv_cnt >= cfg_dv_delay) begin
          div_divisor_tready = 1'b1; cap_b = div_divisor_tdata; got_dv = 1;
        end
        dv_cnt++;
      end else dv_cnt = 0;
      if (got_dd && got_dv) begin
        pend_res = ref_qr(cap_a, cap_b, div_signed);
        pending = 1; lat_cnt = cfg_lat; got_dd = 0; got_dv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (resp_valid) n_rv++;
      if (busy && div_signed !== cur_sgn) sig_bad++;
    end
  end

  always @(posedge clk) begin
    if (resetn && resp_valid && resp_ready) n_resp++;
  end

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic rem, input int hold,
                         output logic [31:0] data, output bit got);
    @(negedge clk);
    cur_sgn = sgn; req_valid = 1'b1; req_src1 = a; req_src2 = b;
    req_signed = sgn; req_rem = rem;
    @(negedge clk);
    req_valid = 1'b0; req_src1 = $urandom; req_src2 = $urandom;
    req_signed = ~sgn; req_rem = ~rem;
    got = 0; data = 'x;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) begin
      data = resp_data;
      repeat (hold) begin
        @(negedge clk);
        if (!resp_valid || resp_data !== data || req_ready) hold_bad++;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, resp_valid, err_timeout, div_dividend_tvalid, div_divisor_tvalid, div_signed} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, resp_valid, err_timeout, div_dividend_tvalid, div_divisor_tvalid, div_signed});
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    n_tests++;
    if ({resp_data, div_dividend_tdata, div_divisor_tdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h required 0", resp_data, div_dividend_tdata, div_divisor_tdata);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [31:0] d; bit got; int r0;
    cfg_dd_delay = 0; cfg_dv_delay = 0; cfg_lat = 3;
    r0 = n_resp;
    run_txn(32'd100, 32'd7, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd14) begin n_fail++; $display("FAIL unsigned_quot: got %h required 0000000e", d); end
    n_tests++;
    if (n_resp !== r0 + 1) begin n_fail++; $display("FAIL unsigned_quot_count: got %0d required %0d", n_resp - r0, 1); end
    r0 = n_resp;
    run_txn(32'd100, 32'd7, 1'b0, 1'b1, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd2) begin n_fail++; $display("FAIL unsigned_rem: got %h required 00000002", d); end
    n_tests++;
    if (n_resp !== r0 + 1) begin n_fail++; $display("FAIL unsigned_rem_count: got %0d required %0d", n_resp - r0, 1); end
    $display("[TB] unsigned 100/7 done");
  endtask

  task automatic test_signed();
    logic [31:0] d; bit got;
    sig_bad = 0;
    run_txn(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL signed_quot: got %h required fffffffd", d); end
    run_txn(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, d, got);
    n_tests++;
    if (!got || d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL signed_rem: got %h required ffffffff", d); end
    n_tests++;
    if (sig_bad !== 0) begin n_fail++; $display("FAIL signed_held: got %0d bad cycles required 0", sig_bad); end
    $display("[TB] signed -7/2 done");
  endtask

  task automatic test_tready_delay();
    logic [31:0] d; bit got;
    cfg_dd_delay = 3; cfg_dv_delay = 0; cfg_lat = 2;
    dd_tv_cycles = 0; dv_tv_cycles = 0; dd_unstable = 0; dv_unstable = 0;
    run_txn(32'd1000, 32'd10, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd100) begin n_fail++; $display("FAIL tready_data: got %h required 00000064", d); end
    n_tests++;
    if (dd_tv_cycles !== 4) begin n_fail++; $display("FAIL dividend_tvalid_cycles: got %0d required 4", dd_tv_cycles); end
    n_tests++;
    if (dv_tv_cycles !== 1) begin n_fail++; $display("FAIL divisor_tvalid_cycles: got %0d required 1", dv_tv_cycles); end
    n_tests++;
    if (dd_unstable + dv_unstable !== 0) begin n_fail++; $display("FAIL tdata_stable: got %0d changes required 0", dd_unstable + dv_unstable); end
    cfg_dd_delay = 0;
    $display("[TB] tready delay done");
  endtask

  task automatic test_cancel();
    logic [31:0] d; bit got, ok; int rv0, nd0;
    // cancel while dividend channel still waiting for tready
    cfg_dd_delay = 3; cfg_dv_delay = 0; cfg_lat = 2;
    rv0 = n_rv; nd0 = n_dout;
    @(negedge clk);
    cur_sgn = 1'b0; req_signed = 1'b0; req_valid = 1'b1; req_src1 = 32'd77; req_src2 = 32'd3;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); cancel = 1'b1;
    n_tests++;
    if (div_dividend_tvalid !== 1'b1) begin n_fail++; $display("FAIL cancel_issue_tvalid: got %b required 1", div_dividend_tvalid); end
    @(negedge clk); cancel = 1'b0;
    wait_idle(ok);
    n_tests++;
    if (!ok || n_rv !== rv0 || n_dout !== nd0 + 1) begin
      n_fail++; $display("FAIL cancel_issue: idle %0d resp %0d douts %0d required 1 0 1", ok, n_rv - rv0, n_dout - nd0);
    end
    cfg_dd_delay = 0;
    run_txn(32'd50, 32'd5, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd10) begin n_fail++; $display("FAIL after_cancel_issue: got %h required 0000000a", d); end
    // cancel during the divider wait
    cfg_lat = 8; rv0 = n_rv; nd0 = n_dout;
    @(negedge clk);
    req_valid = 1'b1; req_src1 = 32'd123; req_src2 = 32'd4;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, div_dividend_tvalid, div_divisor_tvalid} !== 3'b100) begin
      n_fail++; $display("FAIL cancel_wait_state: got %b required 100", {busy, div_dividend_tvalid, div_divisor_tvalid});
    end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    wait_idle(ok);
    n_tests++;
    if (!ok || n_rv !== rv0 || n_dout !== nd0 + 1) begin
      n_fail++; $display("FAIL cancel_wait: idle %0d resp %0d douts %0d required 1 0 1", ok, n_rv - rv0, n_dout - nd0);
    end
    cfg_lat = 2;
    run_txn(32'd50, 32'd5, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd10) begin n_fail++; $display("FAIL after_cancel_wait: got %h required 0000000a", d); end
    // cancel beats a simultaneous request in IDLE
    @(negedge clk);
    req_valid = 1'b1; cancel = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; cancel = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_wins: busy %b required 0", busy); end
    $display("[TB] cancel scenarios done");
  endtask

  task automatic test_resp_hold();
    logic [31:0] d; bit got;
    hold_bad = 0;
    run_txn(32'd200, 32'd9, 1'b0, 1'b0, 5, d, got);
    n_tests++;
    if (!got || d !== 32'd22) begin n_fail++; $display("FAIL hold_data: got %h required 00000016", d); end
    n_tests++;
    if (hold_bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d bad cycles required 0", hold_bad); end
    $display("[TB] response hold done");
  endtask

  task automatic test_random();
    logic [31:0] a, b, d, e; logic sgn, rem; bit got;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 20);
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      sgn = 1'($urandom_range(0, 1)); rem = 1'($urandom_range(0, 1));
      cfg_dd_delay = $urandom_range(0, 3); cfg_dv_delay = $urandom_range(0, 3);
      cfg_lat = $urandom_range(0, 15);
      e = ref_res(a, b, sgn, rem);
      run_txn(a, b, sgn, rem, $urandom_range(0, 2), d, got);
      n_tests++;
      if (!got || d !== e) begin
        n_fail++; $display("FAIL random_%0d: %h/%h s%0d r%0d got %h required %h", i, a, b, sgn, rem, d, e);
      end
    end
    cfg_dd_delay = 0; cfg_dv_delay = 0;
    $display("[TB] random transactions done");
  endtask

  task automatic test_timeout();
    logic [31:0] d; bit got;
    n_tests++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b required 0", err_timeout); end
    cfg_lat = 60;
    run_txn(32'd81, 32'd9, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd9) begin n_fail++; $display("FAIL timeout_data: got %h required 00000009", d); end
    n_tests++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b required 1", err_timeout); end
    cfg_lat = 2;
    run_txn(32'd64, 32'd8, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (err_timeout !== 1'b1 || !got || d !== 32'd8) begin
      n_fail++; $display("FAIL timeout_sticky: err %b data %h required 1 00000008", err_timeout, d);
    end
    $display("[TB] timeout done");
  endtask

  task automatic test_div_zero();
    logic [31:0] d; bit got; int exp_tv;
`ifdef DIV_ZERO_BYPASS_EN
    exp_tv = 0;
`else
    exp_tv = 2;
`endif
    dd_tv_cycles = 0;
    run_txn(32'd9, 32'd0, 1'b0, 1'b0, 0, d, got);
    n_tests++;
    if (!got || d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_quot: got %h required ffffffff", d); end
    run_txn(32'd9, 32'd0, 1'b0, 1'b1, 0, d, got);
    n_tests++;
    if (!got || d !== 32'd9) begin n_fail++; $display("FAIL divzero_rem: got %h required 00000009", d); end
    n_tests++;
    if (dd_tv_cycles !== exp_tv) begin n_fail++; $display("FAIL divzero_tvalid: got %0d required %0d", dd_tv_cycles, exp_tv); end
    $display("[TB] divide by zero done");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_tready_delay();
    test_cancel();
    test_resp_hold();
    test_random();
    test_div_zero();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t required finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
